// File: rtl/label_commit_ctrl.sv
// label_commit_ctrl: tear-free commit of 4-character label strings during vblank.
// Writes land in a shadow buffer and set a pending bit. On the rising edge of
// vertical blanking, pending slots are pushed to the label instances in
// ascending order, one slot per cycle, over a shared string bus with a
// one-hot load strobe.
//
// Ports:
//   Clk, Reset_n             clock, asynchronous active-low reset
//   DrawX, DrawY             VGA scan position (only DrawY is used)
//   wr_en/wr_idx/wr_string   slot write request, accepted when wr_ready
//   wr_ready                 combinational, low while a commit scan runs
//   string_out               shared string bus (registered)
//   load_string              one-hot slot load strobe (registered)
//   busy                     combinational, commit scan in progress
//   frame_commit             one-cycle pulse after a scan completes (registered)
module label_commit_ctrl #(
  parameter int unsigned NUM_LABELS = 8,
  parameter int unsigned IDXW       = $clog2(NUM_LABELS),
  parameter int unsigned VBLANK_Y   = 480
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  wr_en,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [31:0]           wr_string,
  output logic                  wr_ready,
  output logic [31:0]           string_out,
  output logic [NUM_LABELS-1:0] load_string,
  output logic                  busy,
  output logic                  frame_commit
);

  localparam int unsigned STRW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [IDXW-1:0]       r_idx;
  logic [NUM_LABELS-1:0] r_pending;
  logic [STRW-1:0]       r_shadow [NUM_LABELS];
  logic                  r_vblank_q;

  logic w_vblank;
  logic w_edge;
  logic w_wr_fire;
  logic w_wr_hit;
  logic w_unused;

  // DrawX is carried only for VGA bus consistency.
  assign w_unused = ^DrawX;

  assign w_vblank  = (32'(DrawY) >= VBLANK_Y);
  assign w_edge    = w_vblank && !r_vblank_q;

  assign busy      = (r_state != ST_IDLE);
  assign wr_ready  = !busy;
  assign w_wr_fire = wr_en && wr_ready;
  // Out-of-range indices complete the handshake but are dropped.
  assign w_wr_hit  = w_wr_fire && (32'(wr_idx) < NUM_LABELS);

  // Shadow/pending storage, vblank edge detect and commit FSM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_pending    <= '0;
      r_vblank_q   <= 1'b0;
      load_string  <= '0;
      string_out   <= '0;
      frame_commit <= 1'b0;
      for (int i = 0; i < int'(NUM_LABELS); i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_vblank_q <= w_vblank;

      if (w_wr_hit) begin
        r_shadow[wr_idx]  <= wr_string;
        r_pending[wr_idx] <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          load_string  <= '0;
          frame_commit <= 1'b0;
          // A write accepted in the edge cycle counts towards starting the scan.
          if (w_edge && ((|r_pending) || w_wr_hit)) begin
            r_state <= ST_SCAN;
            r_idx   <= '0;
          end
        end

        ST_SCAN: begin
          if (r_pending[r_idx]) begin
            load_string        <= NUM_LABELS'(1) << r_idx;
            string_out         <= r_shadow[r_idx];
            r_pending[r_idx]   <= 1'b0;
          end else begin
            load_string <= '0;
          end
          if (r_idx == IDXW'(NUM_LABELS - 1)) begin
            r_state <= ST_DONE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end

        ST_DONE: begin
          // Two cycles here: the first raises frame_commit, the second shows it
          // while still busy so writers resume the cycle after the pulse.
          load_string <= '0;
          if (!frame_commit) begin
            frame_commit <= 1'b1;
          end else begin
            frame_commit <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/label_commit_ctrl.md
# label_commit_ctrl

Tear-free update controller for the on-screen ASCII label overlays (the 4-character string sprites used for band, gain and frequency readouts). Software/control logic posts new 32-bit strings for any of NUM_LABELS label slots at any time. The controller buffers them and commits them to the label instances only during vertical blanking, one slot per cycle, by driving a shared string bus plus a one-hot load strobe.

## Interface
- NUM_LABELS, 8: number of label slots; 2..16.
- IDXW, $clog2(NUM_LABELS): width of the slot index.
- VBLANK_Y, 480: first DrawY line treated as vertical blanking.

- Clk  in  1  system clock; all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column (unused except for consistency with VGA bus)
- DrawY  in  10  current pixel row
- wr_en  in  1  write request for one label slot
- wr_idx  in  IDXW  target slot
- wr_string  in  32  four ASCII bytes, [31:24] leftmost
- wr_ready  out  1  write accepted when wr_en && wr_ready
- string_out  out  32  shared string bus to all label instances
- load_string  out  NUM_LABELS  one-hot load strobe, bit i loads slot i
- busy  out  1  commit scan in progress
- frame_commit  out  1  one-cycle pulse after a scan completes

## Operation
- Storage: shadow[NUM_LABELS] x 32 bits, pending[NUM_LABELS] bits.
- Accepted write (wr_en && wr_ready && wr_idx < NUM_LABELS): shadow[wr_idx] <= wr_string and pending[wr_idx] <= 1. Last write wins if pending is already set. If wr_idx >= NUM_LABELS, the write is consumed and ignored.
- vblank = (DrawY >= VBLANK_Y), registered each cycle into vblank_q. Edge = vblank && !vblank_q.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on edge with |pending, go to SCAN with idx <= 0. On edge with pending == 0, stay in IDLE with no outputs.
  - SCAN: each cycle, examine slot idx.
    - If pending[idx]: load_string <= 1 << idx, string_out <= shadow[idx], pending[idx] <= 0.
    - Else: load_string <= 0 and string_out holds.
    - idx increments. After idx == NUM_LABELS-1, go to DONE.
  - DONE: frame_commit <= 1 for one cycle, load_string <= 0, then IDLE.
- busy = (state != IDLE). wr_ready = !busy (combinational). Writes are refused during a scan; the writer must hold wr_en until wr_ready.
- At most one load_string bit is high in any cycle. Slots are committed in ascending index order.
- Edges occurring while busy are ignored. A scan always fits inside blanking because NUM_LABELS+2 is far less than one line.

## Timing
- Reset (async assert, sync release internally not required): state=IDLE, idx=0, pending=0, shadow=0, vblank_q=0, load_string=0, string_out=0, frame_commit=0, busy=0, wr_ready=1.
- Reset asserted mid-scan: all pending is discarded and no further strobes occur. Label instances keep their last loaded strings.
- Edge detected in cycle t:
  - state=SCAN at t+1.
  - load_string[i] and the matching string_out are valid together in cycle t+2+i. Consumers latch at the end of that cycle.
  - frame_commit is high in cycle t+2+NUM_LABELS.
  - busy is high during t+1 .. t+2+NUM_LABELS.
  - wr_ready returns to 1 in cycle t+3+NUM_LABELS.
- A write accepted in cycle t (the edge cycle) is included in the scan, because pending is updated before slot examination begins at t+1.
- All outputs except wr_ready and busy are registered.

## Test plan
- Reset then idle frame: no writes, DrawY sweeps 0->524. Required: load_string stays 0, frame_commit never pulses, wr_ready stays 1.
- Single write: slot 3 <= 0x47_41_49_4E ("GAIN") at DrawY=100, then DrawY reaches 480 at cycle t. Required: only load_string=8'b0000_1000, with string_out=0x4741494E, in cycle t+5. frame_commit in cycle t+10.
- Overwrite and multi-slot: slot 0 <= "ABCD", slot 0 <= "WXYZ", slot 7 <= "1234", all before blanking. Required: slot 0 is loaded with "WXYZ" at t+2 and slot 7 with "1234" at t+9. No other strobes occur.
- Write during scan: wr_en held in cycle t+4 for slot 1. Required: wr_ready=0 until t+11. The write is accepted at t+11 and committed only in the next frame's blanking.
- Out-of-range index (NUM_LABELS=6, wr_idx=7): the write completes its handshake, but no pending bit is set and no strobe occurs at blanking.
- Reset mid-scan: pending slots 0, 2 and 5; assert Reset_n=0 at t+3. Required: all outputs go to reset values immediately, and no strobe for slots 2 or 5 ever appears, including in the following frame.
